// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event scheduler.
// Event-type codes, output FSM encoding and an index-width helper.
package button_event_pkg;

   typedef logic [1:0] ev_type_t;

   localparam ev_type_t EV_RELEASE = 2'b00;
   localparam ev_type_t EV_PRESS   = 2'b01;
   localparam ev_type_t EV_REPEAT  = 2'b10;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   // Bits needed to index n channels (at least one).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at pointer and wraps.
// Produces a one-hot grant, the granted index and an any-request flag.
module rr_arbiter
   import button_event_pkg::*;
#(
   parameter int unsigned channels = 4,
   localparam int unsigned IW = idx_w(channels)
) (
   input  logic [channels-1:0] req,
   input  logic [IW-1:0]       pointer,
   output logic [channels-1:0] grant_c,
   output logic [IW-1:0]       index_c,
   output logic                any_c
);

   logic [IW-1:0] cand;

   always_comb begin
      grant_c = '0;
      index_c = '0;
      any_c   = 1'b0;
      cand    = '0;
      for (int unsigned off = 0; off < channels; off++) begin
         cand = IW'((32'(pointer) + off) % channels);
         if (!any_c && req[cand]) begin
            any_c         = 1'b1;
            grant_c[cand] = 1'b1;
            index_c       = cand;
         end
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Queues press/release edge pulses per button and serialises them onto one
// valid/ready event channel. Optional auto-repeat is enabled by BUTTON_REPEAT_EN.
module button_event_scheduler
   import button_event_pkg::*;
#(
   parameter int unsigned channels    = 4,
   parameter int unsigned idwidth     = 2,
   parameter int unsigned repeatwidth = 8,
   parameter int unsigned repeattime  = 200
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [channels-1:0] positiveedge,
   input  logic [channels-1:0] negativeedge,
   input  logic [channels-1:0] conditioned,
   output logic                event_valid,
   input  logic                event_ready,
   output logic [idwidth-1:0]  event_channel,
   output logic [1:0]          event_type,
   output logic [channels-1:0] overflow,
   input  logic [channels-1:0] overflow_clr
);

   localparam int unsigned IW = idx_w(channels);

   state_t              state, state_n;
   logic [IW-1:0]       ptr;
   logic [channels-1:0] pend_press, pend_rel;
   logic [channels-1:0] clr_press, clr_rel, ovf_set;
   logic [channels-1:0] req_c, arb_grant;
   logic [IW-1:0]       arb_index;
   logic                arb_any, load;
   ev_type_t            sel_type;

`ifdef BUTTON_REPEAT_EN
   logic [channels-1:0]    pend_rep, clr_rep, rep_hit;
   logic [repeatwidth-1:0] rep_cnt [channels];

   assign req_c = pend_press | pend_rel | pend_rep;
`else
   assign req_c = pend_press | pend_rel;

   // Repeat parameters only shape hardware when the feature is built.
   if (repeatwidth == 0 || repeattime == 0) begin : g_repeat_cfg_unused
   end
`endif

   rr_arbiter #(.channels(channels)) u_arb (
      .req     (req_c),
      .pointer (ptr),
      .grant_c (arb_grant),
      .index_c (arb_index),
      .any_c   (arb_any)
   );

   // Older event first when both are pending; the current level tells which.
   always_comb begin
      sel_type = EV_RELEASE;
      if (pend_press[arb_index] && pend_rel[arb_index])
         sel_type = conditioned[arb_index] ? EV_RELEASE : EV_PRESS;
      else if (pend_press[arb_index])
         sel_type = EV_PRESS;
`ifdef BUTTON_REPEAT_EN
      else if (!pend_rel[arb_index])
         sel_type = EV_REPEAT;
`endif
   end

   // Output FSM next-state and load decision.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      case (state)
         S_EMPTY: begin
            if (arb_any) begin
               load    = 1'b1;
               state_n = S_FULL;
            end
         end
         S_FULL: begin
            if (event_ready) begin
               if (arb_any) load = 1'b1;
               else         state_n = S_EMPTY;
            end
         end
         default: state_n = S_EMPTY;
      endcase
   end

   always_comb begin
      clr_press = '0;
      clr_rel   = '0;
`ifdef BUTTON_REPEAT_EN
      clr_rep   = '0;
`endif
      if (load) begin
         clr_press = arb_grant & {channels{sel_type == EV_PRESS}};
         clr_rel   = arb_grant & {channels{sel_type == EV_RELEASE}};
`ifdef BUTTON_REPEAT_EN
         clr_rep   = arb_grant & {channels{sel_type == EV_REPEAT}};
`endif
      end
      ovf_set = (positiveedge & pend_press & ~clr_press)
              | (negativeedge & pend_rel & ~clr_rel);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_EMPTY;
         ptr           <= '0;
         event_channel <= '0;
         event_type    <= EV_RELEASE;
      end else begin
         state <= state_n;
         if (load) begin
            event_channel <= idwidth'(arb_index);
            event_type    <= sel_type;
            ptr           <= (arb_index == IW'(channels - 1)) ? '0 : arb_index + IW'(1);
         end
      end
   end

   assign event_valid = (state == S_FULL);

   // Pending flags; a pulse landing on a still-pending bit is merged and flagged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_press <= '0;
         pend_rel   <= '0;
         overflow   <= '0;
      end else begin
         pend_press <= (pend_press & ~clr_press) | positiveedge;
         pend_rel   <= (pend_rel & ~clr_rel) | negativeedge;
         overflow   <= (overflow & ~overflow_clr) | ovf_set;
      end
   end

`ifdef BUTTON_REPEAT_EN
   always_comb begin
      for (int unsigned i = 0; i < channels; i++)
         rep_hit[i] = conditioned[i] && !positiveedge[i]
                   && (rep_cnt[i] == repeatwidth'(repeattime - 1));
   end

   // Hold counters; a repeat already pending silently absorbs further ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_rep <= '0;
         for (int unsigned i = 0; i < channels; i++) rep_cnt[i] <= '0;
      end else begin
         pend_rep <= ((pend_rep & ~clr_rep) | rep_hit) & ~negativeedge;
         for (int unsigned i = 0; i < channels; i++) begin
            if (!conditioned[i] || positiveedge[i] || rep_hit[i])
               rep_cnt[i] <= '0;
            else
               rep_cnt[i] <= rep_cnt[i] + repeatwidth'(1);
         end
      end
   end
`endif

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Collects edge pulses from a bank of per-button input conditioners and queues them as discrete press/release events.
- Shares one event output channel between all buttons using round-robin arbitration and a valid/ready handshake.
- Sits between the input-conditioner bank and the downstream consumer (FSM or CPU-facing register).
- Records lost events per channel in sticky overflow flags.

Parameters:
- channels, 4, number of button channels (2..16)
- idwidth, 2, width of the channel id; must be >= log2(channels)
- repeatwidth, 8, width of the auto-repeat counter (used only with the optional feature)
- repeattime, 200, cycles of continuous hold before each auto-repeat event (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- positiveedge  input  channels  1-cycle rising-edge pulses, one bit per conditioner
- negativeedge  input  channels  1-cycle falling-edge pulses, one bit per conditioner
- conditioned  input  channels  debounced levels, one bit per conditioner
- event_valid  output  1  an event is presented
- event_ready  input  1  consumer accepts the event this cycle
- event_channel  output  idwidth  channel id of the presented event
- event_type  output  2  00 = release, 01 = press, 10 = repeat, 11 = reserved (never driven)
- overflow  output  channels  sticky per-channel lost-event flags
- overflow_clr  input  channels  per-bit clear for overflow

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high on port reset.
- Reset values: event_valid = 0, event_channel = 0, event_type = 00, overflow = 0. All pending bits clear. Round-robin pointer = channel 0.
- Per-channel state: pend_press[i] and pend_rel[i].
  - positiveedge[i] sets pend_press[i]; negativeedge[i] sets pend_rel[i].
- Granting a pending bit clears it.
  - If a new pulse for the same bit arrives in the same cycle as its grant, the bit stays set (new event).
- Overflow:
  - A pulse arriving while its pending bit is already set and not being granted sets overflow[i]; that pulse is merged and dropped.
  - overflow_clr[i] clears overflow[i].
  - If set and clear coincide, set wins.
- Output FSM, two states:
  - EMPTY (event_valid = 0): on any pending bit, load the output register and go to FULL.
  - FULL (event_valid = 1): event_channel and event_type are held stable until event_ready. On ready, either reload from pending (stay FULL, back-to-back, no bubble) or go to EMPTY.
- Latency: a pulse sampled at edge E sets pending at E. event_valid rises at E+1 if the output is free.
- Arbitration:
  - Round-robin over channels whose pend_press or pend_rel is set.
  - The search starts at last_granted+1 and wraps from channels-1 to 0.
  - The pointer advances only on a load.
- Within a channel:
  - If both bits are pending, emit the older event first.
  - The older event is release if conditioned[i] = 1, and press if conditioned[i] = 0.
  - Otherwise emit whichever bit is set.
- event_ready while event_valid = 0 is ignored.
- Reset mid-handshake drops the held event and all pending events.

Optional Feature:
- Macro: BUTTON_REPEAT_EN.
- With the macro defined:
  - Each channel has a repeatwidth-bit counter.
  - The counter clears when conditioned[i] = 0 or on positiveedge[i], and increments while conditioned[i] = 1.
  - On reaching repeattime, it sets pend_rep[i] and reloads to 0.
  - pend_rep has lowest priority within its channel.
  - A pend_rep that is already set absorbs further repeats silently; this does not count as overflow.
  - negativeedge[i] clears pend_rep[i].
- Without the macro: no counters or pend_rep are built, and event_type 10 never appears.

Decomposition:
- Package button_event_pkg holds:
  - event-type constants EV_RELEASE, EV_PRESS, EV_REPEAT
  - FSM state encoding S_EMPTY, S_FULL
- One sub-module, rr_arbiter: combinational request vector plus pointer in, one-hot grant plus index out, parameterised by channels.

Test Plan:
- Single press: positiveedge[2] pulse at cycle 10, event_ready tied 1 -> event_valid at cycle 11 with channel 2, type 01, for one cycle.
- Fairness: positiveedge = 4'b1111 at once, ready = 1 -> four events on consecutive cycles, channels 0,1,2,3 (pointer from reset); a repeat burst yields 0,1,2,3 again.
- Backpressure: ready = 0 for 20 cycles after event (1,01) -> outputs stable throughout; accepted on ready = 1; next event follows on the next cycle.
- Ordering: pulse positiveedge[3] then negativeedge[3] while stalled, conditioned[3] = 0 -> press emitted before release.
- Overflow: two positiveedge[1] pulses while stalled -> overflow = 4'b0010, only one press emitted; overflow_clr[1] -> overflow = 0.
- Reset: assert reset asynchronously while event_valid = 1 with 3 pending -> event_valid drops immediately, no events after release of reset. With BUTTON_REPEAT_EN and repeattime = 5, a 12-cycle hold -> press then two repeat events.
